// File: rtl/lc3_int_seq.sv
// lc3_int_seq: LC-3 interrupt/exception entry and RTI sequencer.
// Owns the PSR. Drives the stack-pointer unit controls and the R6/MAR/MDR/PC
// and memory strobes. These strobes push PSR and PC-1 on entry, then fetch
// the vector. On RTI they pop PC and PSR. The main control FSM hands over at
// an instruction boundary and resumes on seq_done.
module lc3_int_seq #(
    parameter logic [7:0]  VEC_BASE  = 8'h01,
    parameter logic [7:0]  PRIV_VEC  = 8'h00,
    parameter logic [15:0] RESET_PSR = 16'h8002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_boundary,
    input  logic        int_req,
    input  logic [2:0]  int_pri,
    input  logic [7:0]  int_vec,
    input  logic        exc_req,
    input  logic [7:0]  exc_vec,
    input  logic        rti_req,
    input  logic        ld_cc,
    input  logic [2:0]  cc_in,
    input  logic        mem_r,
    input  logic [15:0] bus_in,
    output logic [15:0] main_bus,
    output logic [15:0] psr_out,
    output logic        LDSavedUSP,
    output logic        LDSavedSSP,
    output logic        GateSP,
    output logic [1:0]  SPMUX,
    output logic        sr1_r6,
    output logic        ld_r6,
    output logic        ld_mar,
    output logic        ld_mar_r6,
    output logic        ld_mdr,
    output logic        mio_en,
    output logic        mem_en,
    output logic        mem_we,
    output logic        gate_pc_m1,
    output logic        gate_mdr,
    output logic        ld_pc,
    output logic        busy,
    output logic        seq_done
);

    typedef enum logic [4:0] {
        IDLE,
        E_SAVE, E_DEC1, E_MDR1, E_WR1, E_DEC2, E_MDR2, E_WR2, E_VEC, E_RD, E_PC,
        R_MAR, R_RD1, R_PC, R_INC1, R_RD2, R_PSR, R_INC2, R_USP
    } state_t;

    state_t      state;
    logic [15:0] psr;
    logic [15:0] tmp_psr;
    logic [7:0]  vec;

    logic        accept_exc;
    logic        accept_rti;
    logic        accept_int;
    logic        entry_go;
    logic [7:0]  entry_vec;
    logic        bus_drive;
    logic [15:0] bus_val;

    // Accept priority in IDLE: exception > RTI > interrupt above current priority.
    // A user-mode RTI becomes a privilege exception through PRIV_VEC.
    assign accept_exc = exc_req & fetch_boundary;
    assign accept_rti = ~accept_exc & rti_req;
    assign accept_int = ~accept_exc & ~rti_req & int_req & fetch_boundary &
                        (int_pri > psr[10:8]);
    assign entry_go   = accept_exc | (accept_rti & psr[15]) | accept_int;
    assign entry_vec  = accept_exc ? exc_vec : (accept_int ? int_vec : PRIV_VEC);

    assign psr_out  = psr;
    assign main_bus = bus_drive ? bus_val : 16'hzzzz;

    // Sequencer state, PSR and the context latched when an entry is accepted.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the same pre-edge values.
        if (!rst_n) begin
            state   <= IDLE;
            psr     <= RESET_PSR;
            tmp_psr <= 16'h0000;
            vec     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (entry_go) begin
                        tmp_psr <= psr;
                        vec     <= entry_vec;
                        psr[15] <= 1'b0;
                        if (accept_int) psr[10:8] <= int_pri;
                        // Only a user-mode entry has to park USP and switch to SSP.
                        state   <= psr[15] ? E_SAVE : E_DEC1;
                    end else if (accept_rti) begin
                        state <= R_MAR;
                    end
                end
                E_SAVE: state <= E_DEC1;
                E_DEC1: state <= E_MDR1;
                E_MDR1: state <= E_WR1;
                E_WR1:  if (mem_r) state <= E_DEC2;
                E_DEC2: state <= E_MDR2;
                E_MDR2: state <= E_WR2;
                E_WR2:  if (mem_r) state <= E_VEC;
                E_VEC:  state <= E_RD;
                E_RD:   if (mem_r) state <= E_PC;
                E_PC:   state <= IDLE;
                R_MAR:  state <= R_RD1;
                R_RD1:  if (mem_r) state <= R_PC;
                R_PC:   state <= R_INC1;
                R_INC1: state <= R_RD2;
                R_RD2:  if (mem_r) state <= R_PSR;
                R_PSR:  state <= R_INC2;
                // The popped PSR is already in place here. Returning to user
                // mode needs one more step to swap SSP out and USP back in.
                R_INC2: state <= psr[15] ? R_USP : IDLE;
                R_USP:  state <= IDLE;
                default: state <= IDLE;
            endcase
            // The popped PSR takes precedence over a condition-code update.
            if (state == R_PSR) psr <= bus_in;
            else if (ld_cc)     psr[2:0] <= cc_in;
        end
    end

    // Moore decode of the datapath strobes; only the read strobe also looks at mem_r.
    always_comb begin
        // NOTE: defaults first, so no output holds its value and no latch is inferred.
        LDSavedUSP = 1'b0;
        LDSavedSSP = 1'b0;
        GateSP     = 1'b0;
        SPMUX      = 2'b00;
        ld_r6      = 1'b0;
        ld_mar     = 1'b0;
        ld_mar_r6  = 1'b0;
        ld_mdr     = 1'b0;
        mio_en     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        gate_pc_m1 = 1'b0;
        gate_mdr   = 1'b0;
        ld_pc      = 1'b0;
        seq_done   = 1'b0;
        bus_drive  = 1'b0;
        bus_val    = 16'h0000;
        case (state)
            E_SAVE: begin
                LDSavedUSP = 1'b1; GateSP = 1'b1; SPMUX = 2'b11; ld_r6 = 1'b1;
            end
            E_DEC1, E_DEC2: begin
                GateSP = 1'b1; SPMUX = 2'b10; ld_r6 = 1'b1; ld_mar = 1'b1;
            end
            E_MDR1: begin
                bus_drive = 1'b1; bus_val = tmp_psr; ld_mdr = 1'b1;
            end
            E_WR1, E_WR2: begin
                mem_en = 1'b1; mem_we = 1'b1;
            end
            E_MDR2: begin
                gate_pc_m1 = 1'b1; ld_mdr = 1'b1;
            end
            E_VEC: begin
                bus_drive = 1'b1; bus_val = {VEC_BASE, vec}; ld_mar = 1'b1;
            end
            E_RD, R_RD1, R_RD2: begin
                mem_en = 1'b1; mio_en = 1'b1; ld_mdr = mem_r;
            end
            E_PC: begin
                gate_mdr = 1'b1; ld_pc = 1'b1; seq_done = 1'b1;
            end
            R_MAR: ld_mar_r6 = 1'b1;
            R_PC: begin
                gate_mdr = 1'b1; ld_pc = 1'b1;
            end
            R_INC1: begin
                GateSP = 1'b1; SPMUX = 2'b01; ld_r6 = 1'b1; ld_mar = 1'b1;
            end
            R_PSR: gate_mdr = 1'b1;
            R_INC2: begin
                GateSP = 1'b1; SPMUX = 2'b01; ld_r6 = 1'b1; seq_done = ~psr[15];
            end
            R_USP: begin
                LDSavedSSP = 1'b1; GateSP = 1'b1; SPMUX = 2'b00; ld_r6 = 1'b1;
                seq_done = 1'b1;
            end
            default: ;
        endcase
        sr1_r6 = GateSP | LDSavedUSP | LDSavedSSP;
        busy   = (state != IDLE);
    end

endmodule

// File: tb/tb_lc3_int_seq.sv
// tb_lc3_int_seq: randomized scoreboard bench for lc3_int_seq.
// A small datapath (R6, saved USP/SSP, MAR, MDR, PC, memory) reacts to the
// strobes. A stack-level model predicts pushes, pops, vector reads, PC loads
// and the final PSR. A negedge monitor pops and compares those predictions.
`timescale 1ns/1ps
module tb_lc3_int_seq;

    localparam logic [7:0]  VEC_BASE  = 8'h01;
    localparam logic [7:0]  PRIV_VEC  = 8'h00;
    localparam logic [15:0] RESET_PSR = 16'h8002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_boundary = 1'b0, int_req = 1'b0, exc_req = 1'b0, rti_req = 1'b0;
    logic [2:0]  int_pri = 3'd0;
    logic [7:0]  int_vec = 8'h00, exc_vec = 8'h00;
    logic        ld_cc = 1'b0;
    logic [2:0]  cc_in = 3'd0;
    logic        mem_r = 1'b1;
    logic [15:0] bus_in;
    wire  [15:0] main_bus;
    logic [15:0] psr_out;
    logic        LDSavedUSP, LDSavedSSP, GateSP;
    logic [1:0]  SPMUX;
    logic        sr1_r6, ld_r6, ld_mar, ld_mar_r6, ld_mdr, mio_en, mem_en, mem_we;
    logic        gate_pc_m1, gate_mdr, ld_pc, busy, seq_done;

    lc3_int_seq #(.VEC_BASE(VEC_BASE), .PRIV_VEC(PRIV_VEC), .RESET_PSR(RESET_PSR)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_boundary(fetch_boundary),
        .int_req(int_req), .int_pri(int_pri), .int_vec(int_vec),
        .exc_req(exc_req), .exc_vec(exc_vec), .rti_req(rti_req),
        .ld_cc(ld_cc), .cc_in(cc_in), .mem_r(mem_r), .bus_in(bus_in),
        .main_bus(main_bus), .psr_out(psr_out),
        .LDSavedUSP(LDSavedUSP), .LDSavedSSP(LDSavedSSP), .GateSP(GateSP), .SPMUX(SPMUX),
        .sr1_r6(sr1_r6), .ld_r6(ld_r6), .ld_mar(ld_mar), .ld_mar_r6(ld_mar_r6),
        .ld_mdr(ld_mdr), .mio_en(mio_en), .mem_en(mem_en), .mem_we(mem_we),
        .gate_pc_m1(gate_pc_m1), .gate_mdr(gate_mdr), .ld_pc(ld_pc),
        .busy(busy), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    logic [16:0] strobes;
    assign strobes = {LDSavedUSP, LDSavedSSP, GateSP, SPMUX, sr1_r6, ld_r6, ld_mar, ld_mar_r6,
                      ld_mdr, mio_en, mem_en, mem_we, gate_pc_m1, gate_mdr, ld_pc, seq_done};

    // ---------------- datapath harness ----------------
    logic [15:0] r6, sav_usp, sav_ssp, mar, mdr, pc;
    logic [15:0] mem [0:65535];
    logic        h_load = 1'b0;
    logic [15:0] h_pc, h_r6, h_usp, h_ssp;
    logic        p_en = 1'b0;
    logic [15:0] p_addr, p_data;
    logic [15:0] sp_val, bus;

    always_comb begin
        case (SPMUX)
            2'b00:   sp_val = sav_usp;
            2'b01:   sp_val = r6 + 16'd1;
            2'b10:   sp_val = r6 - 16'd1;
            default: sp_val = sav_ssp;
        endcase
        if (gate_mdr)        bus = mdr;
        else if (gate_pc_m1) bus = pc - 16'd1;
        else if (GateSP)     bus = sp_val;
        else                 bus = main_bus;
    end
    assign bus_in = bus;

    always @(posedge clk) begin
        if (h_load) begin
            pc <= h_pc; r6 <= h_r6; sav_usp <= h_usp; sav_ssp <= h_ssp;
        end else begin
            if (LDSavedUSP) sav_usp <= r6;
            if (LDSavedSSP) sav_ssp <= r6;
            if (ld_r6) r6 <= bus;
            if (ld_mar) mar <= bus;
            else if (ld_mar_r6) mar <= r6;
            if (ld_mdr) mdr <= mio_en ? mem[mar] : bus;
            if (mem_en && mem_we && mem_r) mem[mar] <= mdr;
            if (ld_pc) pc <= bus;
        end
        if (p_en) mem[p_addr] <= p_data;
    end

    // ---------------- scoreboard ----------------
    typedef enum logic [1:0] {EV_WRITE, EV_READ, EV_LDPC, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  flush_gen = 0;

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push(input ev_kind_t k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input string nm, input ev_kind_t k, input logic [15:0] a,
                             input logic [15:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", nm}, 48'(exp_q.size()), 48'd1);
        end else begin
            e = exp_q.pop_front();
            check(nm, {k, a, d}, {e.kind, e.addr, e.data});
        end
    endtask

    // Monitor: samples on the falling edge, away from the state updates.
    initial begin
        int seen_gen;
        seen_gen = 0;
        forever begin
            @(negedge clk);
            if (flush_gen != seen_gen) begin
                exp_q.delete();
                seen_gen = flush_gen;
            end
            if (rst_n) begin
                if (mem_en && mem_we && mem_r) expect_ev("push", EV_WRITE, mar, mdr);
                if (ld_mdr && mio_en)          expect_ev("read_addr", EV_READ, mar, 16'h0);
                if (ld_pc)                     expect_ev("ld_pc_value", EV_LDPC, bus, 16'h0);
                if (seq_done)                  expect_ev("done_psr", EV_DONE, 16'h0, psr_out);
                if (LDSavedUSP) check("save_usp_ctl", {SPMUX, GateSP, ld_r6, sr1_r6}, 5'b11111);
                if (LDSavedSSP) check("usp_restore_ctl", {SPMUX, GateSP, ld_r6, sr1_r6}, 5'b00111);
            end
        end
    end

    // ---------------- reference model (stack level) ----------------
    logic [15:0] m_psr, m_pc, m_r6, m_usp, m_ssp;
    logic [15:0] m_mem [logic [15:0]];

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : 16'h0;
    endfunction

    task automatic model_entry(input bit is_int, input logic [2:0] pri, input logic [7:0] v,
                               output int cyc);
        logic [15:0] old, sp, va;
        old = m_psr;
        sp  = old[15] ? m_ssp : m_r6;
        if (old[15]) m_usp = m_r6;
        push(EV_WRITE, sp - 16'd1, old);          m_mem[sp - 16'd1] = old;
        push(EV_WRITE, sp - 16'd2, m_pc - 16'd1); m_mem[sp - 16'd2] = m_pc - 16'd1;
        va = {VEC_BASE, v};
        push(EV_READ, va, 16'h0);
        m_pc = m_rd(va);
        push(EV_LDPC, m_pc, 16'h0);
        m_psr[15] = 1'b0;
        if (is_int) m_psr[10:8] = pri;
        push(EV_DONE, 16'h0, m_psr);
        m_r6 = sp - 16'd2;
        cyc  = old[15] ? 10 : 9;
    endtask

    task automatic model_rti(output int cyc);
        logic [15:0] sp;
        if (m_psr[15]) begin
            model_entry(1'b0, 3'd0, PRIV_VEC, cyc);
        end else begin
            sp = m_r6;
            push(EV_READ, sp, 16'h0);
            m_pc = m_rd(sp);
            push(EV_LDPC, m_pc, 16'h0);
            push(EV_READ, sp + 16'd1, 16'h0);
            m_psr = m_rd(sp + 16'd1);
            m_r6  = sp + 16'd2;
            if (m_psr[15]) begin
                m_ssp = sp + 16'd2;
                m_r6  = m_usp;
                cyc   = 8;
            end else begin
                cyc = 7;
            end
            push(EV_DONE, 16'h0, m_psr);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        p_en = 1'b1; p_addr = a; p_data = d;
        tick();
        p_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic load_ctx(input logic [15:0] npc, input logic [15:0] nr6,
                            input logic [15:0] nusp, input logic [15:0] nssp);
        h_load = 1'b1; h_pc = npc; h_r6 = nr6; h_usp = nusp; h_ssp = nssp;
        tick();
        h_load = 1'b0;
        m_pc = npc; m_r6 = nr6; m_usp = nusp; m_ssp = nssp;
    endtask

    task automatic clear_reqs();
        fetch_boundary = 1'b0; int_req = 1'b0; exc_req = 1'b0; rti_req = 1'b0; ld_cc = 1'b0;
    endtask

    // Caller has set the request inputs in this slot. Runs until the sequencer
    // returns to IDLE, injecting mem_r stalls and ignored requests meanwhile.
    task automatic run_req(input string nm, input int stalls, input int exp_cycles,
                           input int exp_we);
        int cycles, we_cycles, left;
        cycles = 0; we_cycles = 0; left = stalls;
        tick();
        clear_reqs();
        while (busy && cycles < 200) begin
            cycles++;
            if (mem_en && left > 0) begin mem_r = 1'b0; left--; end
            else mem_r = 1'b1;
            if (mem_en && mem_we) we_cycles++;
            fetch_boundary = 1'($urandom_range(0, 1));
            int_req = 1'($urandom_range(0, 1)); int_pri = 3'd7; int_vec = 8'hEE;
            exc_req = 1'($urandom_range(0, 1)); exc_vec = 8'hDD;
            rti_req = 1'($urandom_range(0, 1));
            tick();
        end
        clear_reqs();
        mem_r = 1'b1;
        check({nm, "_cycles"}, 48'(cycles), 48'(exp_cycles));
        if (exp_we >= 0) check({nm, "_we_cycles"}, 48'(we_cycles), 48'(exp_we));
        check({nm, "_psr"}, psr_out, m_psr);
        check({nm, "_r6"}, r6, m_r6);
        check({nm, "_pending"}, 48'(exp_q.size()), 48'd0);
    endtask

    task automatic do_int(input string nm, input logic [2:0] pri, input logic [7:0] v,
                          input int stalls);
        int cyc;
        cyc = 0;
        poke({VEC_BASE, v}, 16'(16'h4000 + {8'h00, v}));
        if (pri > m_psr[10:8]) model_entry(1'b1, pri, v, cyc);
        fetch_boundary = 1'b1; int_req = 1'b1; int_pri = pri; int_vec = v;
        run_req(nm, stalls, (cyc == 0) ? 0 : cyc + stalls, -1);
    endtask

    task automatic do_exc(input string nm, input logic [7:0] v, input int stalls);
        int cyc;
        poke({VEC_BASE, v}, 16'(16'h6000 + {8'h00, v}));
        model_entry(1'b0, 3'd0, v, cyc);
        fetch_boundary = 1'b1; exc_req = 1'b1; exc_vec = v;
        run_req(nm, stalls, cyc + stalls, -1);
    endtask

    task automatic do_rti(input string nm, input logic [15:0] ret_pc, input logic [15:0] ret_psr,
                          input int stalls, input int exp_we);
        int cyc;
        if (m_psr[15]) begin
            poke({VEC_BASE, PRIV_VEC}, 16'h7700);
        end else begin
            poke(m_r6, ret_pc);
            poke(m_r6 + 16'd1, ret_psr);
        end
        model_rti(cyc);
        rti_req = 1'b1;
        run_req(nm, stalls, cyc + stalls, exp_we);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard, cyc, kind, stalls;
        logic [2:0] cc;

        // Reset
        rst_n = 1'b0;
        m_psr = RESET_PSR;
        tick();
        load_ctx(16'h3000, 16'hFE00, 16'h0000, 16'h3000);
        rst_n = 1'b1;
        check("reset_psr", psr_out, 16'h8002);
        check("reset_busy", busy, 1'b0);
        check("reset_strobes", strobes, 17'h0);

        // User-mode interrupt: full 10-cycle entry through E_SAVE
        do_int("int_user", 3'd4, 8'h80, 0);
        check("int_user_psr_value", psr_out, 16'h0402);
        check("int_user_pushed_psr", mem[16'h2FFF], 16'h8002);
        check("int_user_pushed_pc", mem[16'h2FFE], 16'h2FFF);

        // Priority equal or lower is ignored
        do_int("int_lower", 3'd3, 8'h83, 0);
        do_int("int_equal", 3'd4, 8'h84, 0);

        // Supervisor-mode nested interrupt: 9 cycles
        do_int("int_super", 3'd5, 8'h81, 0);
        check("int_super_psr_value", psr_out, 16'h0502);

        // Exception beats a simultaneous top-priority interrupt
        poke({VEC_BASE, 8'h55}, 16'h5555);
        poke({VEC_BASE, 8'h01}, 16'h6001);
        model_entry(1'b0, 3'd0, 8'h01, cyc);
        fetch_boundary = 1'b1; exc_req = 1'b1; exc_vec = 8'h01;
        int_req = 1'b1; int_pri = 3'd7; int_vec = 8'h55;
        run_req("exc_wins", 0, cyc, -1);
        check("exc_wins_psr_value", psr_out, 16'h0502);

        // RTI staying in supervisor, then RTI back to user
        do_rti("rti_super", 16'h3100, 16'h0002, 0, 0);
        check("rti_super_psr_value", psr_out, 16'h0002);
        do_rti("rti_user", 16'h3005, 16'h8001, 0, 0);
        check("rti_user_psr_value", psr_out, 16'h8001);
        check("rti_user_pc", pc, 16'h3005);

        // Condition codes in IDLE
        ld_cc = 1'b1; cc_in = 3'b010;
        tick();
        ld_cc = 1'b0;
        m_psr[2:0] = 3'b010;
        check("ld_cc_psr", psr_out, 16'h8002);

        // User-mode RTI is a privilege exception; 3 stall cycles in E_WR1
        do_rti("rti_priv", 16'h0000, 16'h0000, 3, 5);
        check("rti_priv_psr_value", psr_out, 16'h0002);

        // Reset in the middle of an entry
        poke({VEC_BASE, 8'h90}, 16'h5090);
        model_entry(1'b1, 3'd2, 8'h90, cyc);
        fetch_boundary = 1'b1; int_req = 1'b1; int_pri = 3'd2; int_vec = 8'h90;
        tick();
        clear_reqs();
        guard = 0;
        while (!gate_pc_m1 && guard < 50) begin guard++; tick(); end
        check("reach_mdr2", gate_pc_m1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        flush_gen++;
        check("midreset_psr", psr_out, 16'h8002);
        check("midreset_busy", busy, 1'b0);
        check("midreset_strobes", strobes, 17'h0);
        m_psr = RESET_PSR;
        load_ctx(16'h3400, 16'hF000, 16'h0000, 16'h2800);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            kind   = $urandom_range(0, 4);
            stalls = $urandom_range(0, 2);
            case (kind)
                0, 1: do_int("rnd_int", 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), stalls);
                2:    do_exc("rnd_exc", 8'($urandom_range(0, 255)), stalls);
                3:    do_rti("rnd_rti", 16'($urandom), 16'($urandom), stalls, -1);
                default: begin
                    cc = 3'($urandom_range(0, 7));
                    ld_cc = 1'b1; cc_in = cc;
                    tick();
                    ld_cc = 1'b0;
                    m_psr[2:0] = cc;
                    check("rnd_ld_cc", psr_out, m_psr);
                end
            endcase
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
